// File: rtl/alu.sv
// 32-bit MIPS execute-stage ALU with a registered result, zero flag and signed-overflow flag.
// Define ALU_SHIFT_EN to add SLL/SRL/SRA on codes 3/4/5; otherwise those codes act as undefined ops.
module alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] z,
   output logic             zero,
   output logic             overflow
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;
`ifdef ALU_SHIFT_EN
   localparam logic [3:0] OP_SLL = 4'b0011;
   localparam logic [3:0] OP_SRL = 4'b0100;
   localparam logic [3:0] OP_SRA = 4'b0101;
`endif

   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] w_z;
   logic             w_ovf;
   logic             w_slt;

   logic [WIDTH-1:0] r_z;
   logic             r_zero;
   logic             r_ovf;

   assign w_sum  = a + b;
   assign w_diff = a - b;
   // Direct signed compare keeps SLT correct even when a-b would overflow.
   assign w_slt  = $signed(a) < $signed(b);

   always_comb begin
      w_z   = '0;
      w_ovf = 1'b0;
      case (op)
         OP_AND: w_z = a & b;
         OP_OR:  w_z = a | b;
         OP_NOR: w_z = ~(a | b);
         OP_ADD: begin
            w_z   = w_sum;
            w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            w_z   = w_diff;
            w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLT: w_z = {{(WIDTH-1){1'b0}}, w_slt};
`ifdef ALU_SHIFT_EN
         OP_SLL: w_z = a << b[4:0];
         OP_SRL: w_z = a >> b[4:0];
         OP_SRA: w_z = $signed(a) >>> b[4:0];
`endif
         default: begin
            w_z   = '0;
            w_ovf = 1'b0;
         end
      endcase
   end

   // zero comes from the same next-state value as z so the pair never disagrees.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_z    <= '0;
         r_zero <= 1'b1;
         r_ovf  <= 1'b0;
      end else begin
         r_z    <= w_z;
         r_zero <= (w_z == '0);
         r_ovf  <= w_ovf;
      end
   end

   assign z        = r_z;
   assign zero     = r_zero;
   assign overflow = r_ovf;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases plus randomized ops against an arithmetic reference model.
module tb_alu;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] z;
   logic        zero;
   logic        overflow;

   int n_checks = 0;
   int n_errors = 0;

   alu #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .op       (op),
      .a        (a),
      .b        (b),
      .z        (z),
      .zero     (zero),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Reference: results computed with 64-bit signed arithmetic, overflow = out of 32-bit signed range.
   function automatic void model(input logic [3:0] m_op, input logic [31:0] m_a, input logic [31:0] m_b,
                                 output logic [31:0] m_z, output logic m_ov);
      longint sa = longint'($signed(m_a));
      longint sb = longint'($signed(m_b));
      longint r  = 0;
      int     sh = int'(m_b % 32);
      m_z  = 32'd0;
      m_ov = 1'b0;
      case (m_op)
         4'd0:  m_z = m_a & m_b;
         4'd1:  m_z = m_a | m_b;
         4'd12: m_z = ~(m_a | m_b);
         4'd2, 4'd6: begin
            r    = (m_op == 4'd2) ? sa + sb : sa - sb;
            m_ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            m_z  = r[31:0];
         end
         4'd7:  m_z = (sa < sb) ? 32'd1 : 32'd0;
`ifdef ALU_SHIFT_EN
         4'd3:  begin r = sa * (64'sd1 << sh); m_z = r[31:0]; end
         4'd4:  m_z = m_a / (32'd1 << sh);
         4'd5:  begin r = sa >>> sh; m_z = r[31:0]; end
`endif
         default: m_z = 32'd0;
      endcase
   endfunction

   // Apply one op, clock it in, then check against model and optionally against a spec constant.
   task automatic run_op(input string tag, input logic [3:0] t_op, input logic [31:0] t_a,
                         input logic [31:0] t_b, input bit use_exp, input logic [31:0] exp_z);
      logic [31:0] mz;
      logic        mov;
      op = t_op; a = t_a; b = t_b;
      model(t_op, t_a, t_b, mz, mov);
      @(posedge clk);
      #1;
      $display("%s: op=%0d a=%h b=%h -> z=%h zero=%b ovf=%b", tag, t_op, t_a, t_b, z, zero, overflow);
      if (use_exp) check({tag, ".spec_z"}, z, exp_z);
      check({tag, ".z"}, z, mz);
      check({tag, ".zero"}, {31'd0, zero}, {31'd0, (mz == 32'd0)});
      check({tag, ".ovf"}, {31'd0, overflow}, {31'd0, mov});
   endtask

   initial begin
      logic [31:0] ops [10];
      logic [31:0] edges [6];
      ops   = '{32'd0, 32'd1, 32'd2, 32'd6, 32'd7, 32'd12, 32'd3, 32'd4, 32'd5, 32'd0};
      edges = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0001};

      rst = 1'b1; op = 4'd2; a = 32'd5; b = 32'd7;
      @(posedge clk); #1;
      $display("reset: z=%h zero=%b ovf=%b", z, zero, overflow);
      check("reset.z", z, 32'd0);
      check("reset.zero", {31'd0, zero}, 32'd1);
      check("reset.ovf", {31'd0, overflow}, 32'd0);
      rst = 1'b0;

      run_op("and",  4'd0,  32'd21, 32'd3, 1, 32'd1);
      run_op("or",   4'd1,  32'd2,  32'd5, 1, 32'd7);
      run_op("nor",  4'd12, 32'd1,  32'd3, 1, 32'hFFFF_FFFC);
      run_op("add",  4'd2,  32'd5,  -32'sd4, 1, 32'd1);
      run_op("sub1", 4'd6,  32'd9,  32'd10, 1, 32'hFFFF_FFFF);
      run_op("sub2", 4'd6,  32'd2,  32'd5,  1, 32'hFFFF_FFFD);
      run_op("sub3", 4'd6,  32'd7,  32'd7,  1, 32'd0);
      run_op("slt1", 4'd7,  32'd1,  32'd3,  1, 32'd1);
      run_op("slt2", 4'd7,  32'd6,  32'd5,  1, 32'd0);
      run_op("slt3", 4'd7,  32'h8000_0000, 32'd1, 1, 32'd1);
      run_op("addov", 4'd2, 32'h7FFF_FFFF, 32'd1, 1, 32'h8000_0000);
      check("addov.flag", {31'd0, overflow}, 32'd1);
      run_op("subov", 4'd6, 32'h8000_0000, 32'd1, 1, 32'h7FFF_FFFF);
      check("subov.flag", {31'd0, overflow}, 32'd1);
      run_op("addz", 4'd2, 32'hFFFF_FFFF, 32'd1, 1, 32'd0);
      check("addz.zero", {31'd0, zero}, 32'd1);
      run_op("undef", 4'd9, 32'd123, 32'd456, 1, 32'd0);
`ifdef ALU_SHIFT_EN
      run_op("op3", 4'd3, 32'd1, 32'd4, 1, 32'd16);
      run_op("sra", 4'd5, -32'sd16, 32'd2, 1, 32'hFFFF_FFFC);
`else
      run_op("op3", 4'd3, 32'd1, 32'd4, 1, 32'd0);
      check("op3.zero", {31'd0, zero}, 32'd1);
`endif

      // Reset in the middle of back-to-back ADDs, then recovery.
      run_op("b2b1", 4'd2, 32'd10, 32'd20, 1, 32'd30);
      rst = 1'b1; op = 4'd2; a = 32'h7FFF_FFFF; b = 32'd1;
      @(posedge clk); #1;
      $display("rst mid-stream: z=%h zero=%b ovf=%b", z, zero, overflow);
      check("rst2.z", z, 32'd0);
      check("rst2.zero", {31'd0, zero}, 32'd1);
      check("rst2.ovf", {31'd0, overflow}, 32'd0);
      rst = 1'b0;
      run_op("b2b2", 4'd2, 32'd40, 32'd2, 1, 32'd42);

      for (int i = 0; i < 300; i++) begin
         logic [3:0]  r_op;
         logic [31:0] ra;
         logic [31:0] rb;
         r_op = (i % 8 == 7) ? 4'($urandom_range(0, 15)) : ops[$urandom_range(0, 9)][3:0];
         ra = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
         rb = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
         if (i % 16 == 5) rb = ra;
         run_op($sformatf("rnd%0d", i), r_op, ra, rb, 0, 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
